// File: rtl/sonata_xl_i2c_target.sv
// I2C register-file target: 7-bit addressed, NumRegs x 8-bit registers with an
// auto-incrementing pointer. The first written byte after the address sets the
// pointer; later written bytes fill registers. Reads stream registers from the pointer.
module sonata_xl_i2c_target #(
   parameter logic [6:0]  TargetAddr = 7'h50,
   parameter int unsigned NumRegs    = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       scl_i,
   input  logic                       sda_i,
   output logic                       sda_oe_o,
   input  logic [$clog2(NumRegs)-1:0] reg_addr_i,
   output logic [7:0]                 reg_rdata_o,
   output logic                       busy_o,
   output logic                       wr_pulse_o
);

   localparam int unsigned AW = $clog2(NumRegs);
   localparam logic [AW-1:0] PtrOne = AW'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK
   } state_t;

   state_t        r_state, w_state_nxt;
   logic          r_scl_meta, r_scl_sync, r_scl_prev;
   logic          r_sda_meta, r_sda_sync, r_sda_prev;
   logic [1:0]    r_warm;
   logic [3:0]    r_bit_cnt;
   logic [7:0]    r_shift;
   logic [AW-1:0] r_ptr;
   logic          r_first;
   logic          r_sda_oe;
   logic          r_wr_pulse;
   logic [7:0]    r_regs [NumRegs];

   logic w_det_en, w_start, w_stop, w_scl_rise, w_scl_fall, w_addr_match, w_byte_done;

   // Synchronise the pads and keep one-cycle-delayed copies for edge detection;
   // the warm-up counter masks detection until the delayed copies hold real pad values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_scl_meta <= 1'b1;
         r_scl_sync <= 1'b1;
         r_scl_prev <= 1'b1;
         r_sda_meta <= 1'b1;
         r_sda_sync <= 1'b1;
         r_sda_prev <= 1'b1;
         r_warm     <= 2'd0;
      end else begin
         // NOTE: non-blocking assignments make this a true three-stage pipeline;
         // blocking ones would collapse it into a single flop.
         r_scl_meta <= scl_i;
         r_scl_sync <= r_scl_meta;
         r_scl_prev <= r_scl_sync;
         r_sda_meta <= sda_i;
         r_sda_sync <= r_sda_meta;
         r_sda_prev <= r_sda_sync;
         if (r_warm != 2'd3) r_warm <= r_warm + 2'd1;
      end
   end

   assign w_det_en     = (r_warm == 2'd3);
   assign w_start      = w_det_en &  r_scl_sync &  r_sda_prev & ~r_sda_sync;
   assign w_stop       = w_det_en &  r_scl_sync & ~r_sda_prev &  r_sda_sync;
   assign w_scl_rise   = w_det_en &  r_scl_sync & ~r_scl_prev;
   assign w_scl_fall   = w_det_en & ~r_scl_sync &  r_scl_prev;
   assign w_addr_match = (r_shift[7:1] == TargetAddr);
   assign w_byte_done  = (r_bit_cnt == 4'd8);

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next-state logic; bus conditions override any bit event in the same cycle.
   always_comb begin
      // NOTE: defaulting every always_comb output first prevents latch inference.
      w_state_nxt = r_state;
      if (w_start) begin
         w_state_nxt = S_ADDR;
      end else if (w_stop) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_ADDR:     if (w_scl_fall && w_byte_done) w_state_nxt = w_addr_match ? S_ADDR_ACK : S_IDLE;
            S_ADDR_ACK: if (w_scl_fall) w_state_nxt = r_shift[0] ? S_TX : S_RX;
            S_RX:       if (w_scl_fall && w_byte_done) w_state_nxt = S_RX_ACK;
            S_RX_ACK:   if (w_scl_fall) w_state_nxt = S_RX;
            S_TX:       if (w_scl_fall && w_byte_done) w_state_nxt = S_TX_ACK;
            S_TX_ACK: begin
               if (w_scl_rise && r_sda_sync) w_state_nxt = S_IDLE;
               else if (w_scl_fall)          w_state_nxt = S_TX;
            end
            default:    w_state_nxt = r_state;
         endcase
      end
   end

   // Datapath: bit shifting, SDA drive, pointer and register file updates.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_bit_cnt  <= 4'd0;
         r_shift    <= 8'h00;
         r_ptr      <= '0;
         r_first    <= 1'b0;
         r_sda_oe   <= 1'b0;
         r_wr_pulse <= 1'b0;
         // NOTE: the register file is small and must read 0 after reset, so it is
         // reset explicitly here rather than left as uninitialised memory.
         for (int i = 0; i < NumRegs; i++) r_regs[i] <= 8'h00;
      end else begin
         r_wr_pulse <= 1'b0;
         if (w_start) begin
            r_bit_cnt <= 4'd0;
            r_sda_oe  <= 1'b0;
         end else if (w_stop) begin
            r_sda_oe  <= 1'b0;
         end else begin
            case (r_state)
               S_ADDR, S_RX: begin
                  if (w_scl_rise && !w_byte_done) begin
                     r_shift   <= {r_shift[6:0], r_sda_sync};
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end
                  if (w_scl_fall && w_byte_done) begin
                     if (r_state == S_ADDR) begin
                        r_sda_oe <= w_addr_match;
                     end else begin
                        r_sda_oe <= 1'b1;
                        if (r_first) begin
                           r_ptr   <= r_shift[AW-1:0];
                           r_first <= 1'b0;
                        end else begin
                           r_regs[r_ptr] <= r_shift;
                           r_wr_pulse    <= 1'b1;
                           r_ptr         <= r_ptr + PtrOne;
                        end
                     end
                  end
               end
               S_ADDR_ACK: begin
                  if (w_scl_fall) begin
                     r_bit_cnt <= 4'd0;
                     if (r_shift[0]) begin
                        r_shift  <= r_regs[r_ptr];
                        r_sda_oe <= ~r_regs[r_ptr][7];
                     end else begin
                        r_sda_oe <= 1'b0;
                        r_first  <= 1'b1;
                     end
                  end
               end
               S_RX_ACK: begin
                  if (w_scl_fall) begin
                     r_sda_oe  <= 1'b0;
                     r_bit_cnt <= 4'd0;
                  end
               end
               S_TX: begin
                  if (w_scl_rise && !w_byte_done) r_bit_cnt <= r_bit_cnt + 4'd1;
                  if (w_scl_fall) begin
                     if (w_byte_done) begin
                        r_sda_oe <= 1'b0;
                        r_ptr    <= r_ptr + PtrOne;
                     end else begin
                        r_shift  <= {r_shift[6:0], 1'b0};
                        r_sda_oe <= ~r_shift[6];
                     end
                  end
               end
               S_TX_ACK: begin
                  // A NACK leaves on the rising edge, so a falling edge here means ACK.
                  if (w_scl_fall) begin
                     r_bit_cnt <= 4'd0;
                     r_shift   <= r_regs[r_ptr];
                     r_sda_oe  <= ~r_regs[r_ptr][7];
                  end
               end
               default: r_sda_oe <= 1'b0;
            endcase
         end
      end
   end

   assign sda_oe_o    = r_sda_oe;
   assign busy_o      = (r_state != S_IDLE);
   assign wr_pulse_o  = r_wr_pulse;
   assign reg_rdata_o = r_regs[reg_addr_i];

endmodule

// File: tb/tb_sonata_xl_i2c_target.sv
// Directed bench for sonata_xl_i2c_target: a bit-level I2C host drives SCL and an
// open-drain SDA (wired-AND with the target) and checks ACKs, read data and registers.
module tb_sonata_xl_i2c_target;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl_drv = 1'b1;
   logic       sda_drv = 1'b1;
   logic       sda_bus;
   logic       sda_oe;
   logic [3:0] reg_addr = 4'd0;
   logic [7:0] reg_rdata;
   logic       busy;
   logic       wr_pulse;

   int n_cmp = 0;
   int n_err = 0;
   int n_pulse = 0;
   bit oe_seen = 1'b0;
   int h = 12;                 // SCL half period in clk cycles
   logic [7:0] mem [16];       // expected register contents

   assign sda_bus = sda_drv & ~sda_oe;

   sonata_xl_i2c_target #(.TargetAddr(7'h50), .NumRegs(16)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .scl_i       (scl_drv),
      .sda_i       (sda_bus),
      .sda_oe_o    (sda_oe),
      .reg_addr_i  (reg_addr),
      .reg_rdata_o (reg_rdata),
      .busy_o      (busy),
      .wr_pulse_o  (wr_pulse)
   );

   // 25-unit clock period (40 MHz at 1 ns units).
   always begin
      #12 clk = 1'b1;
      #13 clk = 1'b0;
   end

   always @(posedge clk) begin
      if (wr_pulse) n_pulse++;
      if (sda_oe)   oe_seen = 1'b1;
   end

   initial begin
      repeat (150000) @(posedge clk);
      $display("FAIL watchdog: run did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // START or repeated START from either SCL level.
   task automatic i2c_start();
      sda_drv = 1'b1; wait_clk(h);
      scl_drv = 1'b1; wait_clk(h);
      sda_drv = 1'b0; wait_clk(h);
      scl_drv = 1'b0; wait_clk(h);
   endtask

   task automatic i2c_stop();
      sda_drv = 1'b0; wait_clk(h);
      scl_drv = 1'b1; wait_clk(h);
      sda_drv = 1'b1; wait_clk(h);
   endtask

   task automatic write_bit(input logic b);
      sda_drv = b;    wait_clk(h);
      scl_drv = 1'b1; wait_clk(h);
      scl_drv = 1'b0; wait_clk(2);
   endtask

   task automatic read_bit(output logic b);
      sda_drv = 1'b1; wait_clk(h);
      scl_drv = 1'b1; wait_clk(h / 2);
      b = sda_bus;    wait_clk(h - h / 2);
      scl_drv = 1'b0; wait_clk(2);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack_n);
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(ack_n);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic nack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         d[i] = b;
      end
      write_bit(nack);
   endtask

   task automatic rd_reg(input logic [3:0] a, output logic [7:0] d);
      reg_addr = a;
      #1 d = reg_rdata;
   endtask

   initial begin
      logic       ack;
      logic [7:0] d;
      int         p0;
      int         pulses0;

      // Reset state.
      wait_clk(4);
      check("rst_oe", sda_oe, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_wr_pulse", wr_pulse, 1'b0);
      rd_reg(4'd3, d); check("rst_reg3", d, 8'h00);
      rst_n = 1'b1;
      wait_clk(10);

      // Write 0x5A, 0xC3 starting at register 3.
      pulses0 = n_pulse;
      i2c_start();
      write_byte(8'hA0, ack); check("w1_addr_ack", ack, 1'b0);
      write_byte(8'h03, ack); check("w1_ptr_ack", ack, 1'b0);
      write_byte(8'h5A, ack); check("w1_d0_ack", ack, 1'b0);
      write_byte(8'hC3, ack); check("w1_d1_ack", ack, 1'b0);
      i2c_stop();
      check("w1_pulses", n_pulse - pulses0, 2);
      rd_reg(4'd3, d); check("w1_reg3", d, 8'h5A);
      rd_reg(4'd4, d); check("w1_reg4", d, 8'hC3);
      check("w1_busy_after_stop", busy, 1'b0);

      // Write across the top: regs[15]=0x11, then wrap to regs[0]=0x22.
      i2c_start();
      write_byte(8'hA0, ack); check("w2_addr_ack", ack, 1'b0);
      write_byte(8'h0F, ack); check("w2_ptr_ack", ack, 1'b0);
      write_byte(8'h11, ack); check("w2_d0_ack", ack, 1'b0);
      write_byte(8'h22, ack); check("w2_d1_ack", ack, 1'b0);
      i2c_stop();
      rd_reg(4'd15, d); check("w2_reg15", d, 8'h11);
      rd_reg(4'd0, d);  check("w2_reg0_wrap", d, 8'h22);

      // Set pointer to 15, repeated START, read two bytes with wrap.
      i2c_start();
      write_byte(8'hA0, ack); check("r1_addr_ack", ack, 1'b0);
      write_byte(8'h0F, ack); check("r1_ptr_ack", ack, 1'b0);
      i2c_start();
      write_byte(8'hA1, ack); check("r1_raddr_ack", ack, 1'b0);
      read_byte(d, 1'b0);     check("r1_byte0", d, 8'h11);
      read_byte(d, 1'b1);     check("r1_byte1_wrap", d, 8'h22);
      check("r1_idle_after_nack", busy, 1'b0);
      i2c_stop();

      // Foreign address 0xA2: no ACK, no drive, no write.
      pulses0 = n_pulse;
      oe_seen = 1'b0;
      i2c_start();
      write_byte(8'hA2, ack); check("na_addr_nack", ack, 1'b1);
      write_byte(8'h03, ack); check("na_ptr_nack", ack, 1'b1);
      write_byte(8'h77, ack); check("na_data_nack", ack, 1'b1);
      i2c_stop();
      check("na_oe_never", oe_seen, 1'b0);
      check("na_pulses", n_pulse - pulses0, 0);
      rd_reg(4'd3, d); check("na_reg3_kept", d, 8'h5A);

      // STOP after 4 data bits: the partial byte is dropped.
      pulses0 = n_pulse;
      i2c_start();
      write_byte(8'hA0, ack); check("ps_addr_ack", ack, 1'b0);
      write_byte(8'h05, ack); check("ps_ptr_ack", ack, 1'b0);
      write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
      i2c_stop();
      check("ps_pulses", n_pulse - pulses0, 0);
      check("ps_busy", busy, 1'b0);
      check("ps_oe", sda_oe, 1'b0);
      rd_reg(4'd5, d); check("ps_reg5", d, 8'h00);

      // Reset while the target drives a 0 bit during a read.
      i2c_start();
      write_byte(8'hA0, ack); check("rr_addr_ack", ack, 1'b0);
      write_byte(8'h01, ack); check("rr_ptr_ack", ack, 1'b0);
      write_byte(8'h3C, ack); check("rr_d0_ack", ack, 1'b0);
      i2c_start();
      write_byte(8'hA0, ack); check("rr_addr2_ack", ack, 1'b0);
      write_byte(8'h01, ack); check("rr_ptr2_ack", ack, 1'b0);
      i2c_start();
      write_byte(8'hA1, ack); check("rr_raddr_ack", ack, 1'b0);
      wait_clk(4);
      check("rr_oe_driving", sda_oe, 1'b1);
      #3 rst_n = 1'b0;
      #1 check("rr_oe_async_release", sda_oe, 1'b0);
      check("rr_busy", busy, 1'b0);
      for (int i = 0; i < 16; i++) begin
         rd_reg(4'(i), d);
         check($sformatf("rr_reg%0d_zero", i), d, 8'h00);
      end
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(4);
      oe_seen = 1'b0;
      write_byte(8'hA0, ack); check("rr_ignore_nack", ack, 1'b1);
      check("rr_ignore_busy", busy, 1'b0);
      check("rr_ignore_oe", oe_seen, 1'b0);
      i2c_stop();

      // Random write-then-readback transactions at 400 kHz SCL.
      h = 50;
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      for (int t = 0; t < 4; t++) begin
         int         n;
         logic [7:0] wd;
         p0 = $urandom_range(0, 15);
         n  = $urandom_range(1, 2);
         pulses0 = n_pulse;
         i2c_start();
         write_byte(8'hA0, ack);     check("rnd_w_addr_ack", ack, 1'b0);
         write_byte(8'(p0), ack);    check("rnd_w_ptr_ack", ack, 1'b0);
         for (int k = 0; k < n; k++) begin
            wd = 8'($urandom);
            mem[(p0 + k) % 16] = wd;
            write_byte(wd, ack);     check("rnd_w_data_ack", ack, 1'b0);
         end
         i2c_stop();
         check("rnd_pulses", n_pulse - pulses0, n);
         i2c_start();
         write_byte(8'hA0, ack);     check("rnd_r_addr_ack", ack, 1'b0);
         write_byte(8'(p0), ack);    check("rnd_r_ptr_ack", ack, 1'b0);
         i2c_start();
         write_byte(8'hA1, ack);     check("rnd_r_raddr_ack", ack, 1'b0);
         for (int k = 0; k < n; k++) begin
            read_byte(d, (k == n - 1));
            check($sformatf("rnd_t%0d_byte%0d", t, k), d, mem[(p0 + k) % 16]);
         end
         i2c_stop();
         check("rnd_busy_after_stop", busy, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
